// File: rtl/sdc_rd_bram_packer_if.sv
// rtl/sdc_rd_bram_packer_if.sv - byte input stream and BRAM port A write bus of the read-data packer
interface sdc_rd_bram_packer_if;
    logic [7:0]  din;
    logic        din_vld;
    logic        din_rdy;
    logic [10:0] bram_addr;
    logic [63:0] bram_din;
    logic        bram_wr;

    // master is the packer side: consumes bytes, drives the RAM port
    modport master (
        input  din,
        input  din_vld,
        output din_rdy,
        output bram_addr,
        output bram_din,
        output bram_wr
    );

    modport slave (
        output din,
        output din_vld,
        input  din_rdy,
        input  bram_addr,
        input  bram_din,
        input  bram_wr
    );
endinterface

// File: rtl/sdc_rd_bram_packer.sv
// rtl/sdc_rd_bram_packer.sv - packs SD read bytes into 64-bit words and writes them to the read-data BRAM
// SDC_PACK_BIG_ENDIAN_EN: first byte of each word lands in [63:56] instead of [7:0].
module sdc_rd_bram_packer #(
    parameter int BRAM_DEPTH    = 1040,
    parameter int WORDS_PER_BLK = 64,
    parameter int MAX_BLKS      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [10:0]                 base_addr,
    input  logic [4:0]                  blk_cnt,
    sdc_rd_bram_packer_if.master        bus,
    output logic                        blk_done,
    output logic                        done,
    output logic                        err,
    output logic                        busy,
    output logic [10:0]                 words_wr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [2:0]  byte_idx_q,  byte_idx_d;
    logic [63:0] shift_q,     shift_d;
    logic [10:0] base_q,      base_d;
    logic [4:0]  blks_left_q, blks_left_d;
    logic [10:0] words_wr_q,  words_wr_d;
    logic [10:0] bram_addr_q, bram_addr_d;
    logic [63:0] bram_din_q,  bram_din_d;
    logic        bram_wr_q,   bram_wr_d;
    logic        blk_done_q,  blk_done_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;

    logic [11:0] req_end;
    logic        req_bad;
    logic [63:0] shift_in;
    logic [11:0] words_next;
    logic        blk_end;

    // 12-bit end address so base + span cannot wrap before the depth check
    assign req_end = {1'b0, base_addr} + (12'(blk_cnt) * 12'(WORDS_PER_BLK));
    assign req_bad = (blk_cnt == 5'd0) || (blk_cnt > 5'(MAX_BLKS)) || (req_end > 12'(BRAM_DEPTH));

`ifdef SDC_PACK_BIG_ENDIAN_EN
    assign shift_in = {shift_q[55:0], bus.din};
`else
    assign shift_in = {bus.din, shift_q[63:8]};
`endif

    assign words_next = 12'(words_wr_q) + 12'd1;
    assign blk_end    = ((words_next % 12'(WORDS_PER_BLK)) == 12'd0);

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        base_d      = base_q;
        blks_left_d = blks_left_q;
        words_wr_d  = words_wr_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_wr_d   = 1'b0;
        blk_done_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (req_bad) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        base_d      = base_addr;
                        blks_left_d = blk_cnt;
                        words_wr_d  = 11'd0;
                        err_d       = 1'b0;
                        byte_idx_d  = 3'd0;
                        shift_d     = 64'd0;
                        state_d     = ST_RECV;
                    end
                end
            end

            ST_RECV: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    byte_idx_d = 3'd0;
                    shift_d    = 64'd0;
                end else if (bus.din_vld) begin
                    shift_d    = shift_in;
                    byte_idx_d = byte_idx_q + 3'd1;
                    if (byte_idx_q == 3'd7) begin
                        // write lands next cycle while the next word is already filling
                        bram_wr_d   = 1'b1;
                        bram_din_d  = shift_in;
                        bram_addr_d = base_q + words_wr_q;
                        words_wr_d  = words_next[10:0];
                        if (blk_end) begin
                            blk_done_d  = 1'b1;
                            blks_left_d = blks_left_q - 5'd1;
                            if (blks_left_q == 5'd1) begin
                                state_d = ST_FIN;
                            end
                        end
                    end
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 3'd0;
            shift_q     <= 64'd0;
            base_q      <= 11'd0;
            blks_left_q <= 5'd0;
            words_wr_q  <= 11'd0;
            bram_addr_q <= 11'd0;
            bram_din_q  <= 64'd0;
            bram_wr_q   <= 1'b0;
            blk_done_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            base_q      <= base_d;
            blks_left_q <= blks_left_d;
            words_wr_q  <= words_wr_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_wr_q   <= bram_wr_d;
            blk_done_q  <= blk_done_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.din_rdy   = (state_q == ST_RECV);
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign bus.bram_wr   = bram_wr_q;
    assign blk_done      = blk_done_q;
    assign done          = done_q;
    assign err           = err_q;
    assign busy          = (state_q != ST_IDLE);
    assign words_wr      = words_wr_q;

endmodule
